// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
//   Parametrised 2-read/1-write register file for the MIPS32 decode stage.
//   Features: synchronous full reset, optional hardwired zero register,
//   combinational reads, and a scrub engine that zeroes the array one entry
//   per cycle after a ClearReq pulse.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> same-cycle write-to-read bypass (write-through) in IDLE
//     undefined -> reads show the stored value until the write edge
//
// Parameters:
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH
//   ZERO_REG    1: entry 0 reads 0 and ignores writes; 0: ordinary register
//
// Ports:
//   CLK           clock, rising-edge
//   RST           synchronous active-high reset
//   WriteEn       write strobe
//   WriteAddress  write index
//   WriteData     write value
//   ReadAddress1  read port 1 index
//   ReadAddress2  read port 2 index
//   ReadData1     read port 1 data (combinational)
//   ReadData2     read port 2 data (combinational)
//   ClearReq      single-cycle pulse that starts a full-array scrub
//   Busy          high while the scrub is running
// -----------------------------------------------------------------------------
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WriteEn,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadAddress1,
  input  logic [ADDR_WIDTH-1:0] ReadAddress2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  ClearReq,
  output logic                  Busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] w_count_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_wr_en;
  logic                  w_byp1;
  logic                  w_byp2;
  logic                  w_zero1;
  logic                  w_zero2;

  // Next-state and output decode.
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wr_en     = 1'b0;
    Busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A write in the same cycle as ClearReq lands first; the scrub
        // begins with the following edge.
        w_wr_en = WriteEn && !((ZERO_REG != 0) && (WriteAddress == '0));
        if (ClearReq) begin
          w_state_nxt = ST_CLEAR;
          w_count_nxt = '0;
        end
      end
      ST_CLEAR: begin
        Busy        = 1'b1;
        // Counter wraps naturally from DEPTH-1 back to 0 on exit.
        w_count_nxt = r_count + 1'b1;
        if (&r_count) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: the array is cleared by reset on purpose (reads must be 0 after
  // reset); this keeps it in flops rather than a RAM macro without reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == ST_CLEAR) begin
      r_mem[r_count] <= '0;
    end else if (w_wr_en) begin
      r_mem[WriteAddress] <= WriteData;
    end
  end

  // w_wr_en is only active in IDLE and never targets the zero register, so
  // the bypass inherits both restrictions; RST is excluded explicitly.
  assign w_byp1  = BYPASS && !RST && w_wr_en && (WriteAddress == ReadAddress1);
  assign w_byp2  = BYPASS && !RST && w_wr_en && (WriteAddress == ReadAddress2);
  assign w_zero1 = (ZERO_REG != 0) && (ReadAddress1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (ReadAddress2 == '0);

  always_comb begin
    if (w_zero1)     ReadData1 = '0;
    else if (w_byp1) ReadData1 = WriteData;
    else             ReadData1 = r_mem[ReadAddress1];
  end

  always_comb begin
    if (w_zero2)     ReadData2 = '0;
    else if (w_byp2) ReadData2 = WriteData;
    else             ReadData2 = r_mem[ReadAddress2];
  end

endmodule

// File: tb/tb_regfile_param.sv
// -----------------------------------------------------------------------------
// tb_regfile_param
//   Self-checking bench for regfile_param (default parameters). A behavioural
//   model (an array plus a scrub position) tracks the register file; every
//   cycle both read ports and Busy are compared just before the active edge.
// -----------------------------------------------------------------------------
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          WriteEn = 1'b0;
  logic [AW-1:0] WriteAddress = '0;
  logic [DW-1:0] WriteData = '0;
  logic [AW-1:0] ReadAddress1 = '0;
  logic [AW-1:0] ReadAddress2 = '0;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic          ClearReq = 1'b0;
  logic          Busy;

  always #5 CLK = ~CLK;

  regfile_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG  (1)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WriteEn     (WriteEn),
    .WriteAddress(WriteAddress),
    .WriteData   (WriteData),
    .ReadAddress1(ReadAddress1),
    .ReadAddress2(ReadAddress2),
    .ReadData1   (ReadData1),
    .ReadData2   (ReadData2),
    .ClearReq    (ClearReq),
    .Busy        (Busy)
  );

  // Reference model: stored contents and scrub position (-1 = not scrubbing).
  logic [DW-1:0] m_mem [DEPTH];
  int            m_scrub = -1;
  bit            m_valid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] obs_rd1;
  logic [DW-1:0] obs_rd2;
  logic          obs_busy;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && m_scrub < 0 && !RST && WriteEn && WriteAddress == a)
      return WriteData;
    return m_mem[a];
  endfunction

  // One clock: drive at the falling edge, compare before the rising edge,
  // then advance the model with the same inputs.
  task automatic step(input logic rst, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] r1,
                      input logic [AW-1:0] r2, input logic clr);
    @(negedge CLK);
    RST = rst; WriteEn = we; WriteAddress = wa; WriteData = wd;
    ReadAddress1 = r1; ReadAddress2 = r2; ClearReq = clr;
    #1;
    obs_rd1  = ReadData1;
    obs_rd2  = ReadData2;
    obs_busy = Busy;
    if (m_valid) begin
      check("rd1", ReadData1, exp_rd(r1));
      check("rd2", ReadData2, exp_rd(r2));
      check("busy", {31'b0, Busy}, {31'b0, (m_scrub >= 0)});
    end
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_scrub = -1;
      m_valid = 1'b1;
    end else if (m_scrub >= 0) begin
      m_mem[m_scrub] = '0;
      m_scrub++;
      if (m_scrub == DEPTH) m_scrub = -1;
    end else begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (clr) m_scrub = 0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b0, 1'b1, a, d, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(1'b0, 1'b0, '0, '0, a1, a2, 1'b0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a), AW'(DEPTH - 1 - a));
      check(tag, obs_rd1, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // Reset, then every address reads 0 on both ports with Busy low.
    step(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);
    read_all_zero("reset_zero");
    check("reset_busy", {31'b0, obs_busy}, '0);

    // Basic write/read.
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rd(5'd5, 5'd31);
    check("r5", obs_rd1, 32'hDEADBEEF);
    check("r31", obs_rd2, 32'h12345678);

    // Zero register discards writes.
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    check("zero_reg", obs_rd1, '0);

    // Write-through behaviour depends on the build option.
    wr(5'd7, 32'h1);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
    check("byp_pre", obs_rd1, BYP ? 32'hA5A5A5A5 : 32'h1);
    rd(5'd7, 5'd0);
    check("byp_post", obs_rd1, 32'hA5A5A5A5);

    // Scrub: fill, pulse ClearReq, count Busy cycles, drop a mid-scrub write.
    for (int a = 1; a < DEPTH; a++) wr(AW'(a), DW'(a));
    step(1'b0, 1'b0, '0, '0, 5'd3, 5'd30, 1'b1);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (cnt == 5) step(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd31, 1'b0);
      else          step(1'b0, 1'b0, '0, '0, 5'd3, AW'(k), 1'b0);
      if (!obs_busy) break;
      cnt++;
    end
    check("scrub_len", DW'(cnt), 32'd32);
    read_all_zero("scrub_zero");

    // Reset in the middle of a scrub aborts it.
    for (int a = 1; a < DEPTH; a++) wr(AW'(a), DW'(a) + 32'h100);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 10; k++) rd(AW'(k + 1), AW'(20 + k));
    step(1'b1, 1'b0, '0, '0, 5'd15, 5'd16, 1'b0);
    rd(5'd15, 5'd16);
    check("abort_busy", {31'b0, obs_busy}, '0);
    check("abort_r15", obs_rd1, '0);
    read_all_zero("abort_zero");
    wr(5'd2, 32'h9);
    rd(5'd2, 5'd0);
    check("abort_wr", obs_rd1, 32'h9);

    // Randomised traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic          r_rst, r_we, r_clr;
      logic [AW-1:0] r_wa, r_a1, r_a2;
      r_rst = ($urandom_range(0, 99) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_clr = ($urandom_range(0, 49) == 0);
      r_wa  = AW'($urandom);
      r_a1  = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom);
      r_a2  = ($urandom_range(0, 3) == 0) ? r_wa : AW'($urandom);
      step(r_rst, r_we, r_wa, DW'($urandom), r_a1, r_a2, r_clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the core's 2-read/1-write register file, generalised in data width and depth.
- Adds a synchronous full reset, a hardwired zero register (MIPS $zero), and a same-cycle write-to-read bypass.
- Adds a sequential scrub engine that zeroes the array one entry per cycle on request.
- Sits in the decode stage of the MIPS32 datapath, feeding ALU operands and taking writeback data.

Parameters:
- DATA_WIDTH, 32, width of each register in bits.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded; when 0 entry 0 is an ordinary register.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-high reset.
- WriteEn  input  1  write strobe, sampled on rising CLK.
- WriteAddress  input  ADDR_WIDTH  write index.
- WriteData  input  DATA_WIDTH  write value.
- ReadAddress1  input  ADDR_WIDTH  read port 1 index.
- ReadAddress2  input  ADDR_WIDTH  read port 2 index.
- ReadData1  output  DATA_WIDTH  read port 1 data (combinational).
- ReadData2  output  DATA_WIDTH  read port 2 data (combinational).
- ClearReq  input  1  single-cycle pulse; starts scrub of the whole array.
- Busy  output  1  high while scrub is in progress.

Behaviour:
- Reset: RST high at a rising CLK sets every entry to 0, FSM to IDLE, scrub counter to 0 and Busy to 0.
  - After reset, ReadData1 and ReadData2 are 0 for every address.
  - RST has priority over WriteEn and ClearReq in the same cycle.
- Write: in IDLE, WriteEn=1 stores WriteData to array[WriteAddress] at the rising edge.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Read: ReadDataN = array[ReadAddressN], combinational with zero cycles latency.
  - With ZERO_REG=1, address 0 always returns 0.
  - Both ports may read the same address at once.
- FSM states:
  - IDLE: Busy=0. ClearReq=1 goes to CLEAR with counter=0. If ClearReq and WriteEn are both high in that cycle, the write is performed first and the scrub starts next cycle.
  - CLEAR: Busy=1. Each cycle writes 0 to array[counter] and increments counter. After writing entry DEPTH-1, returns to IDLE; Busy falls on the cycle after the last entry is cleared. A scrub takes exactly DEPTH cycles, e.g. 32 cycles for ADDR_WIDTH=5.
- During CLEAR:
  - WriteEn is ignored; the write is dropped and the bypass is inactive.
  - ClearReq is ignored.
  - Reads return current array contents: already-scrubbed entries read 0, the rest read their old values.
- RST during CLEAR aborts the scrub: array zeroed, FSM to IDLE, Busy=0 on the next cycle.
- Counter is ADDR_WIDTH bits wide and wraps from DEPTH-1 to 0 on exit. No other wrap behaviour exists.
- No X on outputs after the first reset; uninitialised-array reads before reset are undefined and not checked.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, if WriteEn=1, WriteAddress==ReadAddressN, and the address is not the zero register (when ZERO_REG=1), then ReadDataN = WriteData in the same cycle (write-through).
- Not defined: ReadDataN shows the old stored value until the rising edge, then the new value.
- The bypass never applies in CLEAR or while RST is high.

Test Plan:
- Reset, then read: RST=1 for 1 cycle, then read all 32 addresses on both ports -> every value 32'h0, Busy=0.
- Write/read: write 32'hDEADBEEF to r5 and 32'h12345678 to r31; read ReadAddress1=5, ReadAddress2=31 -> 32'hDEADBEEF and 32'h12345678.
- Zero register: with ZERO_REG=1, write 32'hFFFFFFFF to r0 -> ReadData1 at address 0 stays 32'h0.
- Bypass:
  - With REGFILE_BYPASS_EN, WriteEn=1, WriteAddress=7, WriteData=32'hA5A5A5A5, ReadAddress1=7 in the same cycle, r7 previously 32'h1 -> ReadData1=32'hA5A5A5A5 before the edge.
  - Without REGFILE_BYPASS_EN -> ReadData1=32'h1 before the edge, 32'hA5A5A5A5 after.
- Scrub:
  - Fill r1..r31 with their index values, then pulse ClearReq.
  - Busy must be high for exactly 32 cycles.
  - A write of 32'h55 to r3 issued mid-scrub is dropped.
  - After Busy falls, all entries read 0.
- Reset mid-scrub: pulse ClearReq, assert RST on scrub cycle 10 -> next cycle Busy=0, FSM in IDLE, all entries 0, and a new write of 32'h9 to r2 is accepted.
